// File: rtl/gpio_ext_pkg.sv
// Shared register map for the GPIO extension block.
// The RTL, the testbench and the software header all take their register offsets from here.
package gpio_ext_pkg;

    localparam logic [7:0] ADDR_DIR      = 8'h00;
    localparam logic [7:0] ADDR_OUT      = 8'h04;
    localparam logic [7:0] ADDR_IN       = 8'h08;
    localparam logic [7:0] ADDR_OUT_SET  = 8'h0C;
    localparam logic [7:0] ADDR_OUT_CLR  = 8'h10;
    localparam logic [7:0] ADDR_OUT_TGL  = 8'h14;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'h18;
    localparam logic [7:0] ADDR_IRQ_RISE = 8'h1C;
    localparam logic [7:0] ADDR_IRQ_FALL = 8'h20;
    localparam logic [7:0] ADDR_IRQ_STAT = 8'h24;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer that brings the asynchronous pin inputs into the clk domain.
module gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_ext.sv
// Memory-mapped GPIO block with atomic set/clear/toggle of the outputs
// and per-pin rising/falling-edge interrupts.
module gpio_ext
    import gpio_ext_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic             we,
    input  logic             re,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_dir,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             irq
);

    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_rise;
    logic [WIDTH-1:0] irq_fall;
    logic [WIDTH-1:0] irq_stat;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev_in;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] rd_value;

    // Reads have no side effects, so the read strobe and the bus bits above WIDTH are not needed.
    logic unused_bits;
    assign unused_bits = ^{re, write_data};

    assign wr_data = write_data[WIDTH-1:0];

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gpio_in),
        .q     (sync_in)
    );

    assign set_mask = (sync_in & ~prev_in & irq_rise) | (~sync_in & prev_in & irq_fall);
    assign clr_mask = (we && address == ADDR_IRQ_STAT) ? wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_reg  <= '0;
            out_reg  <= '0;
            irq_en   <= '0;
            irq_rise <= '0;
            irq_fall <= '0;
        end else if (we) begin
            case (address)
                ADDR_DIR:      dir_reg  <= wr_data;
                ADDR_OUT:      out_reg  <= wr_data;
                ADDR_OUT_SET:  out_reg  <= out_reg | wr_data;
                ADDR_OUT_CLR:  out_reg  <= out_reg & ~wr_data;
                ADDR_OUT_TGL:  out_reg  <= out_reg ^ wr_data;
                ADDR_IRQ_EN:   irq_en   <= wr_data;
                ADDR_IRQ_RISE: irq_rise <= wr_data;
                ADDR_IRQ_FALL: irq_fall <= wr_data;
                default:       ;
            endcase
        end
    end

    // A new edge event overrides a simultaneous write-one-to-clear on the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_in  <= '0;
            irq_stat <= '0;
        end else begin
            prev_in  <= sync_in;
            irq_stat <= (irq_stat & ~clr_mask) | set_mask;
        end
    end

    always_comb begin
        rd_value = '0;
        case (address)
            ADDR_DIR:      rd_value = dir_reg;
            ADDR_OUT:      rd_value = out_reg;
            ADDR_IN:       rd_value = sync_in;
            ADDR_IRQ_EN:   rd_value = irq_en;
            ADDR_IRQ_RISE: rd_value = irq_rise;
            ADDR_IRQ_FALL: rd_value = irq_fall;
            ADDR_IRQ_STAT: rd_value = irq_stat;
            default:       rd_value = '0;
        endcase
        read_data = '0;
        read_data[WIDTH-1:0] = rd_value;
    end

    assign gpio_out = out_reg;
    assign gpio_dir = dir_reg;
    assign irq      = |(irq_stat & irq_en);

endmodule

// File: tb/tb_gpio_ext.sv
// Directed and randomized checks of gpio_ext against a queue-based behavioural model
// of the register map, the input synchronizer delay and the edge interrupts.
module tb_gpio_ext;
    import gpio_ext_pkg::*;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk;
    logic         rst_n;
    logic [7:0]   address;
    logic [31:0]  write_data;
    logic [31:0]  read_data;
    logic         we;
    logic         re;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_dir;
    logic [W-1:0] gpio_in;
    logic         irq;

    int pass_count = 0;
    int fail_count = 0;
    int total_checks = 0;

    logic [W-1:0] m_dir, m_out, m_en, m_rise, m_fall, m_stat, m_prev;
    logic [W-1:0] sync_q [$];

    logic [7:0] reg_list [10] = '{ADDR_DIR, ADDR_OUT, ADDR_IN, ADDR_OUT_SET, ADDR_OUT_CLR,
                                  ADDR_OUT_TGL, ADDR_IRQ_EN, ADDR_IRQ_RISE, ADDR_IRQ_FALL,
                                  ADDR_IRQ_STAT};
    logic [7:0] rand_addr [14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                                   8'h1C, 8'h20, 8'h24, 8'h28, 8'h3C, 8'h01, 8'hFC};

    gpio_ext #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .we         (we),
        .re         (re),
        .gpio_out   (gpio_out),
        .gpio_dir   (gpio_dir),
        .gpio_in    (gpio_in),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_dir = '0; m_out = '0; m_en = '0; m_rise = '0; m_fall = '0; m_stat = '0; m_prev = '0;
        sync_q.delete();
        repeat (S) sync_q.push_back('0);
    endtask

    // The pin value seen by software is the pin value sampled S edges ago.
    task automatic model_edge();
        logic [W-1:0] seen, events, d, clr;
        seen   = sync_q[0];
        events = (seen & ~m_prev & m_rise) | (~seen & m_prev & m_fall);
        d      = write_data[W-1:0];
        clr    = (we && address == ADDR_IRQ_STAT) ? d : '0;
        m_stat = (m_stat & ~clr) | events;
        if (we) begin
            case (address)
                ADDR_DIR:      m_dir  = d;
                ADDR_OUT:      m_out  = d;
                ADDR_OUT_SET:  m_out  = m_out | d;
                ADDR_OUT_CLR:  m_out  = m_out & ~d;
                ADDR_OUT_TGL:  m_out  = m_out ^ d;
                ADDR_IRQ_EN:   m_en   = d;
                ADDR_IRQ_RISE: m_rise = d;
                ADDR_IRQ_FALL: m_fall = d;
                default:       ;
            endcase
        end
        m_prev = seen;
        sync_q.push_back(gpio_in);
        void'(sync_q.pop_front());
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [W-1:0] v;
        case (a)
            ADDR_DIR:      v = m_dir;
            ADDR_OUT:      v = m_out;
            ADDR_IN:       v = sync_q[0];
            ADDR_IRQ_EN:   v = m_en;
            ADDR_IRQ_RISE: v = m_rise;
            ADDR_IRQ_FALL: v = m_fall;
            ADDR_IRQ_STAT: v = m_stat;
            default:       v = '0;
        endcase
        return {{(32-W){1'b0}}, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        address    = a;
        write_data = d;
        we         = 1'b1;
        tick();
        we         = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check_output(tag, read_data, exp);
    endtask

    task automatic apply_stimulus(input int cycles);
        repeat (cycles) tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        address    = '0;
        write_data = '0;
        we         = 1'b0;
        re         = 1'b0;
        gpio_in    = '0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (reg_list[i]) check_reg($sformatf("reset_reg_%02h", reg_list[i]), reg_list[i], 32'h0);
        check_output("reset_gpio_out", {24'h0, gpio_out}, 32'h0);
        check_output("reset_gpio_dir", {24'h0, gpio_dir}, 32'h0);
        check_output("reset_irq", {31'h0, irq}, 32'h0);

        write_reg(ADDR_DIR, 32'hFF);
        write_reg(ADDR_OUT, 32'h0F);
        check_output("dir_pins", {24'h0, gpio_dir}, 32'hFF);
        write_reg(ADDR_OUT_SET, 32'h30);
        check_output("out_set", {24'h0, gpio_out}, 32'h3F);
        write_reg(ADDR_OUT_CLR, 32'h03);
        check_output("out_clr", {24'h0, gpio_out}, 32'h3C);
        write_reg(ADDR_OUT_TGL, 32'h81);
        check_output("out_tgl", {24'h0, gpio_out}, 32'hBD);
        check_reg("out_read", ADDR_OUT, 32'hBD);
        check_reg("set_reads_zero", ADDR_OUT_SET, 32'h0);
        write_reg(ADDR_IN, 32'h55);
        check_reg("in_write_ignored", ADDR_IN, 32'h0);

        gpio_in = 8'hA5;
        tick();
        check_reg("in_after_edge1", ADDR_IN, 32'h00);
        tick();
        check_reg("in_after_edge2", ADDR_IN, 32'hA5);
        gpio_in = 8'h00;
        apply_stimulus(3);
        check_reg("no_stat_without_enable", ADDR_IRQ_STAT, 32'h0);

        write_reg(ADDR_IRQ_RISE, 32'h01);
        write_reg(ADDR_IRQ_EN, 32'h01);
        gpio_in = 8'h01;
        tick();
        tick();
        check_reg("rise_not_yet", ADDR_IRQ_STAT, 32'h00);
        tick();
        check_reg("rise_stat", ADDR_IRQ_STAT, 32'h01);
        check_output("rise_irq", {31'h0, irq}, 32'h1);
        write_reg(ADDR_IRQ_STAT, 32'h01);
        check_output("rise_irq_cleared", {31'h0, irq}, 32'h0);

        gpio_in = 8'h03;
        apply_stimulus(3);
        write_reg(ADDR_IRQ_EN, 32'h00);
        write_reg(ADDR_IRQ_FALL, 32'h02);
        gpio_in = 8'h01;
        apply_stimulus(3);
        check_reg("fall_stat", ADDR_IRQ_STAT, 32'h02);
        check_output("fall_irq_masked", {31'h0, irq}, 32'h0);
        write_reg(ADDR_IRQ_EN, 32'h02);
        check_output("fall_irq_enabled", {31'h0, irq}, 32'h1);

        write_reg(ADDR_IRQ_STAT, 32'h02);
        write_reg(ADDR_IRQ_EN, 32'h01);
        gpio_in = 8'h00;
        apply_stimulus(3);
        gpio_in = 8'h01;
        apply_stimulus(3);
        gpio_in = 8'h00;
        apply_stimulus(3);
        check_reg("stat_before_race", ADDR_IRQ_STAT, 32'h01);
        gpio_in = 8'h01;
        tick();
        tick();
        write_reg(ADDR_IRQ_STAT, 32'h01);
        check_reg("set_beats_clear", ADDR_IRQ_STAT, 32'h01);
        check_output("set_beats_clear_irq", {31'h0, irq}, 32'h1);

        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_irq", {31'h0, irq}, 32'h0);
        check_output("async_rst_out", {24'h0, gpio_out}, 32'h0);
        check_output("async_rst_dir", {24'h0, gpio_dir}, 32'h0);
        foreach (reg_list[i]) check_reg($sformatf("async_rst_reg_%02h", reg_list[i]), reg_list[i], 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            if ($urandom_range(0, 1) == 1) gpio_in = W'($urandom);
            a          = rand_addr[$urandom_range(0, 13)];
            address    = a;
            write_data = $urandom;
            we         = ($urandom_range(0, 2) != 0);
            tick();
            we = 1'b0;
            check_output($sformatf("rnd_out_%0d", n), {24'h0, gpio_out}, {24'h0, m_out});
            check_output($sformatf("rnd_dir_%0d", n), {24'h0, gpio_dir}, {24'h0, m_dir});
            check_output($sformatf("rnd_irq_%0d", n), {31'h0, irq}, {31'h0, |(m_stat & m_en)});
            a = rand_addr[$urandom_range(0, 13)];
            check_reg($sformatf("rnd_rd_%02h_%0d", a, n), a, model_read(a));
        end

        gpio_in = 8'hFF;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(4);
        check_reg("held_high_no_stat", ADDR_IRQ_STAT, 32'h0);
        check_reg("held_high_in", ADDR_IN, 32'hFF);
        check_output("held_high_irq", {31'h0, irq}, 32'h0);

        $display("%0d/%0d checks passed", pass_count, total_checks);
        $finish;
    end

endmodule
